// File: rtl/exec_pkg.sv
// Shared types and constants for the execute stage: ALU op codes, branch
// funct3 encodings, forwarding selects and the multiplier FSM states.
package exec_pkg;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_AND   = 4'd2,
      ALU_OR    = 4'd3,
      ALU_XOR   = 4'd4,
      ALU_SLT   = 4'd5,
      ALU_SLTU  = 4'd6,
      ALU_SLL   = 4'd7,
      ALU_SRL   = 4'd8,
      ALU_SRA   = 4'd9,
      ALU_PASSB = 4'd10,
      ALU_MUL   = 4'd11
   } alu_op_e;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef enum logic [1:0] {
      MUL_IDLE = 2'd0,
      MUL_BUSY = 2'd1,
      MUL_DONE = 2'd2
   } mul_state_e;

endpackage

// File: rtl/iter_mul.sv
// Iterative shift-add multiplier producing the low DATA_WIDTH product bits.
// The start cycle performs the first step, BUSY the remaining DATA_WIDTH-1,
// then one DONE cycle presents the product.
module iter_mul
   import exec_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  flush,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] result
);

   localparam int unsigned CNT_W = $clog2(DATA_WIDTH);

   mul_state_e            state;
   logic [DATA_WIDTH-1:0] acc;
   logic [DATA_WIDTH-1:0] mcand;
   logic [DATA_WIDTH-1:0] mplier;
   logic [CNT_W-1:0]      cnt;

   assign result = acc;

   // Multiplier FSM with shift-add datapath and registered busy/done flags
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= MUL_IDLE;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         cnt    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         case (state)
            MUL_IDLE: begin
               done <= 1'b0;
               if (start && !flush) begin
                  acc    <= b[0] ? a : '0;
                  mcand  <= a << 1;
                  mplier <= b >> 1;
                  cnt    <= CNT_W'(DATA_WIDTH - 2);
                  busy   <= 1'b1;
                  state  <= MUL_BUSY;
               end
            end
            MUL_BUSY: begin
               if (flush) begin
                  busy  <= 1'b0;
                  state <= MUL_IDLE;
               end else begin
                  acc    <= acc + (mplier[0] ? mcand : '0);
                  mcand  <= mcand << 1;
                  mplier <= mplier >> 1;
                  if (cnt == '0) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= MUL_DONE;
                  end else begin
                     cnt <= cnt - CNT_W'(1);
                  end
               end
            end
            MUL_DONE: begin
               done  <= 1'b0;
               state <= MUL_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= MUL_IDLE;
            end
         endcase
      end
   end

endmodule

// File: rtl/exec_stage.sv
// Execute stage: D/E pipeline register, operand forwarding, ALU, branch
// resolution and E/M pipeline register.
// Define EXEC_STAGE_MUL_EN to build the iterative multiplier for the MUL op;
// without it MUL yields 0 and the stage never stalls.
module exec_stage
   import exec_pkg::*;
#(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned CONTROL_WIDTH  = 4,
   parameter int unsigned REG_ADDR_WIDTH = 5
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en_i,
   input  logic                      flush_i,
   input  logic                      valid_d_i,
   input  logic                      regwrite_d_i,
   input  logic [1:0]                resultsrc_d_i,
   input  logic                      memwrite_d_i,
   input  logic                      jump_d_i,
   input  logic                      branch_d_i,
   input  logic                      alusrc_d_i,
   input  logic [CONTROL_WIDTH-1:0]  alucontrol_d_i,
   input  logic [2:0]                funct3_d_i,
   input  logic [DATA_WIDTH-1:0]     rd1_d_i,
   input  logic [DATA_WIDTH-1:0]     rd2_d_i,
   input  logic [DATA_WIDTH-1:0]     pc_d_i,
   input  logic [DATA_WIDTH-1:0]     pcplus4_d_i,
   input  logic [DATA_WIDTH-1:0]     extimm_d_i,
   input  logic [REG_ADDR_WIDTH-1:0] rs1_d_i,
   input  logic [REG_ADDR_WIDTH-1:0] rs2_d_i,
   input  logic [REG_ADDR_WIDTH-1:0] rd_d_i,
   input  logic [1:0]                fwd_a_i,
   input  logic [1:0]                fwd_b_i,
   input  logic [DATA_WIDTH-1:0]     result_w_i,
   output logic [REG_ADDR_WIDTH-1:0] rs1_e_o,
   output logic [REG_ADDR_WIDTH-1:0] rs2_e_o,
   output logic [REG_ADDR_WIDTH-1:0] rd_e_o,
   output logic [1:0]                resultsrc_e_o,
   output logic                      busy_o,
   output logic                      pc_src_o,
   output logic [DATA_WIDTH-1:0]     pc_target_o,
   output logic                      valid_m_o,
   output logic                      regwrite_m_o,
   output logic                      memwrite_m_o,
   output logic [1:0]                resultsrc_m_o,
   output logic [2:0]                funct3_m_o,
   output logic [DATA_WIDTH-1:0]     alu_result_m_o,
   output logic [DATA_WIDTH-1:0]     write_data_m_o,
   output logic [DATA_WIDTH-1:0]     pcplus4_m_o,
   output logic [REG_ADDR_WIDTH-1:0] rd_m_o
);

   localparam int unsigned SHAMT_W = $clog2(DATA_WIDTH);

   logic                     valid_e;
   logic                     regwrite_e;
   logic                     memwrite_e;
   logic                     jump_e;
   logic                     branch_e;
   logic                     alusrc_e;
   logic [CONTROL_WIDTH-1:0] alucontrol_e;
   logic [2:0]               funct3_e;
   logic [DATA_WIDTH-1:0]    rd1_e;
   logic [DATA_WIDTH-1:0]    rd2_e;
   logic [DATA_WIDTH-1:0]    pc_e;
   logic [DATA_WIDTH-1:0]    pcplus4_e;
   logic [DATA_WIDTH-1:0]    extimm_e;

   logic [DATA_WIDTH-1:0]    src_a;
   logic [DATA_WIDTH-1:0]    write_data_e;
   logic [DATA_WIDTH-1:0]    src_b;
   logic [SHAMT_W-1:0]       shamt;
   logic [DATA_WIDTH-1:0]    alu_result_e;
   logic [DATA_WIDTH-1:0]    mul_result;
   logic                     cond;

   // D/E register: flush kills the control bits even while held
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_e       <= 1'b0;
         regwrite_e    <= 1'b0;
         resultsrc_e_o <= '0;
         memwrite_e    <= 1'b0;
         jump_e        <= 1'b0;
         branch_e      <= 1'b0;
         alusrc_e      <= 1'b0;
         alucontrol_e  <= '0;
         funct3_e      <= '0;
         rd1_e         <= '0;
         rd2_e         <= '0;
         pc_e          <= '0;
         pcplus4_e     <= '0;
         extimm_e      <= '0;
         rs1_e_o       <= '0;
         rs2_e_o       <= '0;
         rd_e_o        <= '0;
      end else if (flush_i) begin
         valid_e    <= 1'b0;
         regwrite_e <= 1'b0;
         memwrite_e <= 1'b0;
         jump_e     <= 1'b0;
         branch_e   <= 1'b0;
      end else if (en_i) begin
         valid_e       <= valid_d_i;
         regwrite_e    <= regwrite_d_i;
         resultsrc_e_o <= resultsrc_d_i;
         memwrite_e    <= memwrite_d_i;
         jump_e        <= jump_d_i;
         branch_e      <= branch_d_i;
         alusrc_e      <= alusrc_d_i;
         alucontrol_e  <= alucontrol_d_i;
         funct3_e      <= funct3_d_i;
         rd1_e         <= rd1_d_i;
         rd2_e         <= rd2_d_i;
         pc_e          <= pc_d_i;
         pcplus4_e     <= pcplus4_d_i;
         extimm_e      <= extimm_d_i;
         rs1_e_o       <= rs1_d_i;
         rs2_e_o       <= rs2_d_i;
         rd_e_o        <= rd_d_i;
      end
   end

   // Forwarding muxes for operand A and the store/write-data operand
   always_comb begin
      src_a = rd1_e;
      case (fwd_a_i)
         FWD_WB:  src_a = result_w_i;
         FWD_MEM: src_a = alu_result_m_o;
         default: src_a = rd1_e;
      endcase
      write_data_e = rd2_e;
      case (fwd_b_i)
         FWD_WB:  write_data_e = result_w_i;
         FWD_MEM: write_data_e = alu_result_m_o;
         default: write_data_e = rd2_e;
      endcase
   end

   assign src_b = alusrc_e ? extimm_e : write_data_e;
   assign shamt = src_b[SHAMT_W-1:0];

   // ALU
   always_comb begin
      alu_result_e = '0;
      case (alucontrol_e)
         CONTROL_WIDTH'(ALU_ADD):   alu_result_e = src_a + src_b;
         CONTROL_WIDTH'(ALU_SUB):   alu_result_e = src_a - src_b;
         CONTROL_WIDTH'(ALU_AND):   alu_result_e = src_a & src_b;
         CONTROL_WIDTH'(ALU_OR):    alu_result_e = src_a | src_b;
         CONTROL_WIDTH'(ALU_XOR):   alu_result_e = src_a ^ src_b;
         CONTROL_WIDTH'(ALU_SLT):   alu_result_e = DATA_WIDTH'($signed(src_a) < $signed(src_b));
         CONTROL_WIDTH'(ALU_SLTU):  alu_result_e = DATA_WIDTH'(src_a < src_b);
         CONTROL_WIDTH'(ALU_SLL):   alu_result_e = src_a << shamt;
         CONTROL_WIDTH'(ALU_SRL):   alu_result_e = src_a >> shamt;
         CONTROL_WIDTH'(ALU_SRA):   alu_result_e = DATA_WIDTH'($signed(src_a) >>> shamt);
         CONTROL_WIDTH'(ALU_PASSB): alu_result_e = src_b;
         CONTROL_WIDTH'(ALU_MUL):   alu_result_e = mul_result;
         default:                   alu_result_e = '0;
      endcase
   end

   // Branch condition from funct3; unknown encodings never branch
   always_comb begin
      cond = 1'b0;
      case (funct3_e)
         F3_BEQ:  cond = (src_a == src_b);
         F3_BNE:  cond = (src_a != src_b);
         F3_BLT:  cond = ($signed(src_a) < $signed(src_b));
         F3_BGE:  cond = ($signed(src_a) >= $signed(src_b));
         F3_BLTU: cond = (src_a < src_b);
         F3_BGEU: cond = (src_a >= src_b);
         default: cond = 1'b0;
      endcase
   end

   assign pc_target_o = pc_e + extimm_e;
   assign pc_src_o    = valid_e & (jump_e | (branch_e & cond));

`ifdef EXEC_STAGE_MUL_EN
   logic is_mul_e;
   logic mul_start;
   logic mul_busy;
   logic mul_done;

   assign is_mul_e  = (alucontrol_e == CONTROL_WIDTH'(ALU_MUL));
   assign busy_o    = valid_e & is_mul_e & ~mul_done;
   assign mul_start = valid_e & is_mul_e & ~mul_busy & ~mul_done;

   iter_mul #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_iter_mul (
      .clk    (clk),
      .rst    (rst),
      .start  (mul_start),
      .flush  (flush_i),
      .a      (src_a),
      .b      (src_b),
      .busy   (mul_busy),
      .done   (mul_done),
      .result (mul_result)
   );
`else
   assign busy_o     = 1'b0;
   assign mul_result = '0;
`endif

   // E/M register: a stalled multiply sends bubbles downstream
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_m_o      <= 1'b0;
         regwrite_m_o   <= 1'b0;
         memwrite_m_o   <= 1'b0;
         resultsrc_m_o  <= '0;
         funct3_m_o     <= '0;
         alu_result_m_o <= '0;
         write_data_m_o <= '0;
         pcplus4_m_o    <= '0;
         rd_m_o         <= '0;
      end else begin
         valid_m_o      <= valid_e & ~busy_o;
         regwrite_m_o   <= valid_e & regwrite_e & ~busy_o;
         memwrite_m_o   <= valid_e & memwrite_e & ~busy_o;
         resultsrc_m_o  <= resultsrc_e_o;
         funct3_m_o     <= funct3_e;
         alu_result_m_o <= alu_result_e;
         write_data_m_o <= write_data_e;
         pcplus4_m_o    <= pcplus4_e;
         rd_m_o         <= rd_e_o;
      end
   end

endmodule

// File: tb/tb_exec_stage.sv
// Scoreboard bench for exec_stage: expected M results are queued when an
// instruction sits in E and checked by a monitor when valid_m_o appears.
module tb_exec_stage;
   import exec_pkg::*;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          en_i, flush_i, valid_d_i;
   logic          regwrite_d_i, memwrite_d_i, jump_d_i, branch_d_i, alusrc_d_i;
   logic [1:0]    resultsrc_d_i;
   logic [3:0]    alucontrol_d_i;
   logic [2:0]    funct3_d_i;
   logic [DW-1:0] rd1_d_i, rd2_d_i, pc_d_i, pcplus4_d_i, extimm_d_i;
   logic [AW-1:0] rs1_d_i, rs2_d_i, rd_d_i;
   logic [1:0]    fwd_a_i, fwd_b_i;
   logic [DW-1:0] result_w_i;
   logic [AW-1:0] rs1_e_o, rs2_e_o, rd_e_o;
   logic [1:0]    resultsrc_e_o;
   logic          busy_o, pc_src_o;
   logic [DW-1:0] pc_target_o;
   logic          valid_m_o, regwrite_m_o, memwrite_m_o;
   logic [1:0]    resultsrc_m_o;
   logic [2:0]    funct3_m_o;
   logic [DW-1:0] alu_result_m_o, write_data_m_o, pcplus4_m_o;
   logic [AW-1:0] rd_m_o;

   typedef struct packed {
      logic [DW-1:0] alu;
      logic [AW-1:0] rd;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   exec_stage dut (
      .clk(clk), .rst(rst), .en_i(en_i), .flush_i(flush_i), .valid_d_i(valid_d_i),
      .regwrite_d_i(regwrite_d_i), .resultsrc_d_i(resultsrc_d_i), .memwrite_d_i(memwrite_d_i),
      .jump_d_i(jump_d_i), .branch_d_i(branch_d_i), .alusrc_d_i(alusrc_d_i),
      .alucontrol_d_i(alucontrol_d_i), .funct3_d_i(funct3_d_i),
      .rd1_d_i(rd1_d_i), .rd2_d_i(rd2_d_i), .pc_d_i(pc_d_i), .pcplus4_d_i(pcplus4_d_i),
      .extimm_d_i(extimm_d_i), .rs1_d_i(rs1_d_i), .rs2_d_i(rs2_d_i), .rd_d_i(rd_d_i),
      .fwd_a_i(fwd_a_i), .fwd_b_i(fwd_b_i), .result_w_i(result_w_i),
      .rs1_e_o(rs1_e_o), .rs2_e_o(rs2_e_o), .rd_e_o(rd_e_o), .resultsrc_e_o(resultsrc_e_o),
      .busy_o(busy_o), .pc_src_o(pc_src_o), .pc_target_o(pc_target_o),
      .valid_m_o(valid_m_o), .regwrite_m_o(regwrite_m_o), .memwrite_m_o(memwrite_m_o),
      .resultsrc_m_o(resultsrc_m_o), .funct3_m_o(funct3_m_o),
      .alu_result_m_o(alu_result_m_o), .write_data_m_o(write_data_m_o),
      .pcplus4_m_o(pcplus4_m_o), .rd_m_o(rd_m_o)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog expired: time limit reached before summary");
      $fatal(1);
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Monitor: every valid M slot must match the oldest queued expectation
   always @(negedge clk) begin
      if (rst && valid_m_o) begin
         exp_t e;
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL m_unexpected: valid_m_o with alu 0x%0h rd %0d, expected no result",
                     alu_result_m_o, rd_m_o);
         end else begin
            e = exp_q.pop_front();
            if (alu_result_m_o !== e.alu || rd_m_o !== e.rd) begin
               n_bad++;
               $display("FAIL m_result: got alu 0x%0h rd %0d, expected alu 0x%0h rd %0d",
                        alu_result_m_o, rd_m_o, e.alu, e.rd);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic push(input logic [DW-1:0] alu, input logic [AW-1:0] rd);
      exp_t e;
      e.alu = alu;
      e.rd  = rd;
      exp_q.push_back(e);
   endtask

   task automatic drive_d(input logic [3:0] op, input logic [DW-1:0] rd1, input logic [DW-1:0] rd2,
                          input logic [DW-1:0] imm, input logic asrc, input logic [2:0] f3,
                          input logic br, input logic jmp, input logic [AW-1:0] rd);
      valid_d_i      = 1'b1;
      en_i           = 1'b1;
      regwrite_d_i   = ~br;
      resultsrc_d_i  = 2'b00;
      memwrite_d_i   = 1'b0;
      jump_d_i       = jmp;
      branch_d_i     = br;
      alusrc_d_i     = asrc;
      alucontrol_d_i = op;
      funct3_d_i     = f3;
      rd1_d_i        = rd1;
      rd2_d_i        = rd2;
      pc_d_i         = 32'h100;
      pcplus4_d_i    = 32'h104;
      extimm_d_i     = imm;
      rs1_d_i        = rd + 5'd1;
      rs2_d_i        = rd + 5'd2;
      rd_d_i         = rd;
   endtask

   task automatic bubble();
      valid_d_i    = 1'b0;
      regwrite_d_i = 1'b0;
      jump_d_i     = 1'b0;
      branch_d_i   = 1'b0;
      en_i         = 1'b1;
   endtask

   function automatic logic [127:0] all_regs();
      return {valid_m_o, regwrite_m_o, memwrite_m_o, resultsrc_m_o, funct3_m_o, alu_result_m_o,
              write_data_m_o, pcplus4_m_o, rd_m_o, rs1_e_o, rs2_e_o, rd_e_o, resultsrc_e_o, busy_o};
   endfunction

`ifdef EXEC_STAGE_MUL_EN
   // Runs a held MUL in E until busy drops; returns busy cycle count
   task automatic run_mul(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [AW-1:0] rd,
                          input logic [DW-1:0] prod);
      int cnt = 0;
      int bad = 0;
      drive_d(4'(ALU_MUL), a, b, 32'h0, 1'b0, 3'b000, 1'b0, 1'b0, rd);
      tick();
      valid_d_i = 1'b0;
      en_i      = 1'b0;
      while (busy_o && cnt < 100) begin
         cnt++;
         if (valid_m_o) bad++;
         tick();
      end
      check("mul_busy_cycles", 128'(cnt), 128'd32);
      check("mul_m_bubbles", 128'(bad), 128'd0);
      push(prod, rd);
      bubble();
      tick();
      check("mul_valid_m", {127'd0, valid_m_o}, 128'd1);
   endtask
`endif

   localparam int N_ALU = 12;
   localparam int N_BR  = 7;

   initial begin
      logic [3:0]    t_op [N_ALU];
      logic [DW-1:0] t_a  [N_ALU];
      logic [DW-1:0] t_b  [N_ALU];
      logic [DW-1:0] t_r  [N_ALU];
      logic [2:0]    b_f3 [N_BR];
      logic [DW-1:0] b_a  [N_BR];
      logic [DW-1:0] b_b  [N_BR];
      logic          b_pc [N_BR];
      logic [DW-1:0] b_r  [N_BR];

      t_op = '{4'(ALU_SUB), 4'(ALU_AND), 4'(ALU_OR), 4'(ALU_XOR), 4'(ALU_SLT), 4'(ALU_SLTU),
               4'(ALU_SLL), 4'(ALU_SRL), 4'(ALU_SRA), 4'(ALU_PASSB), 4'd15, 4'(ALU_ADD)};
      t_a  = '{32'd5, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hFFFFFFFF, 32'hFFFFFFFF,
               32'd1, 32'h80000000, 32'h80000000, 32'd99, 32'd5, 32'hFFFFFFFF};
      t_b  = '{32'd7, 32'h0FF00FF0, 32'h0FF00FF0, 32'h0FF00FF0, 32'd1, 32'd1,
               32'h24, 32'd4, 32'd4, 32'h1234, 32'd7, 32'd2};
      t_r  = '{32'hFFFFFFFE, 32'h00F000F0, 32'hFFF0FFF0, 32'hFF00FF00, 32'd1, 32'd0,
               32'h10, 32'h08000000, 32'hF8000000, 32'h1234, 32'd0, 32'd1};

      b_f3 = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b000, 3'b001, 3'b010};
      b_a  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5, 32'd5, 32'd5};
      b_b  = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd5, 32'd5, 32'd5};
      b_pc = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      b_r  = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd10, 32'd10, 32'd10};

      rst = 1'b0;
      flush_i = 1'b0;
      fwd_a_i = FWD_RF;
      fwd_b_i = FWD_RF;
      result_w_i = '0;
      drive_d(4'(ALU_ADD), 32'd0, 32'd0, 32'd0, 1'b0, 3'b000, 1'b0, 1'b0, 5'd0);
      bubble();
      en_i = 1'b0;
      @(negedge clk);
      check("reset_state", all_regs(), 128'd0);
      check("reset_pc", {pc_src_o, pc_target_o}, 128'd0);
      rst = 1'b1;

      // ADD with immediate, result at M one edge after E
      drive_d(4'(ALU_ADD), 32'd5, 32'd0, 32'd7, 1'b1, 3'b000, 1'b0, 1'b0, 5'd1);
      tick();
      push(32'd12, 5'd1);
      bubble();
      tick();

      // Back-to-back ALU ops through the register operand path
      for (int i = 0; i < N_ALU; i++) begin
         drive_d(t_op[i], t_a[i], t_b[i], 32'h0, 1'b0, 3'b000, 1'b0, 1'b0, 5'(i + 2));
         tick();
         push(t_r[i], 5'(i + 2));
      end
      bubble();
      tick();
      tick();

      // Forwarding from M then from W
      drive_d(4'(ALU_ADD), 32'h10, 32'd0, 32'd0, 1'b1, 3'b000, 1'b0, 1'b0, 5'd20);
      tick();
      push(32'h10, 5'd20);
      drive_d(4'(ALU_SUB), 32'd0, 32'd3, 32'd0, 1'b0, 3'b000, 1'b0, 1'b0, 5'd21);
      tick();
      fwd_a_i = FWD_MEM;
      push(32'h0D, 5'd21);
      drive_d(4'(ALU_SUB), 32'd0, 32'd3, 32'd0, 1'b0, 3'b000, 1'b0, 1'b0, 5'd22);
      tick();
      fwd_a_i = FWD_WB;
      result_w_i = 32'd9;
      push(32'd6, 5'd22);
      bubble();
      tick();
      fwd_a_i = FWD_RF;
      tick();

      // Branch resolution and target
      for (int i = 0; i < N_BR; i++) begin
         drive_d(4'(ALU_ADD), b_a[i], b_b[i], 32'hFFFFFFF8, 1'b0, b_f3[i], 1'b1, 1'b0, 5'd0);
         tick();
         check($sformatf("br_pc_src_f3_%0d", b_f3[i]), {127'd0, pc_src_o}, {127'd0, b_pc[i]});
         push(b_r[i], 5'd0);
      end
      check("br_pc_target", 128'(pc_target_o), 128'h0F8);
      bubble();
      tick();
      tick();

      // Jump in E, then flush with en=0 kills it
      drive_d(4'(ALU_ADD), 32'd0, 32'd0, 32'd4, 1'b1, 3'b000, 1'b0, 1'b1, 5'd9);
      tick();
      check("jump_pc_src", {127'd0, pc_src_o}, 128'd1);
      push(32'd4, 5'd9);
      en_i = 1'b0;
      flush_i = 1'b1;
      tick();
      check("flush_pc_src", {127'd0, pc_src_o}, 128'd0);
      flush_i = 1'b0;
      tick();
      check("flush_valid_m", {127'd0, valid_m_o}, 128'd0);
      bubble();
      tick();

`ifdef EXEC_STAGE_MUL_EN
      run_mul(32'd7, 32'd6, 5'd5, 32'd42);
      tick();

      // Reset in the middle of a multiply
      drive_d(4'(ALU_MUL), 32'd7, 32'd6, 32'h0, 1'b0, 3'b000, 1'b0, 1'b0, 5'd5);
      tick();
      valid_d_i = 1'b0;
      en_i = 1'b0;
      repeat (10) tick();
      check("mul_busy_before_rst", {127'd0, busy_o}, 128'd1);
      #2;
      rst = 1'b0;
      #1;
      check("rst_async_busy", {127'd0, busy_o}, 128'd0);
      check("rst_async_regs", all_regs(), 128'd0);
      @(negedge clk);
      rst = 1'b1;
      check("post_rst_idle", {127'd0, busy_o}, 128'd0);
      run_mul(32'd3, 32'd5, 5'd6, 32'd15);
`else
      // MUL without the multiplier: result 0, no stall
      drive_d(4'(ALU_MUL), 32'd7, 32'd6, 32'h0, 1'b0, 3'b000, 1'b0, 1'b0, 5'd5);
      tick();
      check("mul_disabled_busy", {127'd0, busy_o}, 128'd0);
      push(32'd0, 5'd5);
      bubble();
      tick();

      // Reset mid-stream with live instructions in E and M
      drive_d(4'(ALU_ADD), 32'd1, 32'd2, 32'h0, 1'b0, 3'b000, 1'b0, 1'b0, 5'd6);
      tick();
      push(32'd3, 5'd6);
      drive_d(4'(ALU_ADD), 32'd4, 32'd4, 32'h0, 1'b0, 3'b000, 1'b0, 1'b0, 5'd7);
      tick();
      bubble();
      #2;
      rst = 1'b0;
      #1;
      check("rst_async_busy", {127'd0, busy_o}, 128'd0);
      check("rst_async_regs", all_regs(), 128'd0);
      @(negedge clk);
      rst = 1'b1;
`endif
      bubble();
      tick();
      tick();
      check("scoreboard_drained", 128'(exp_q.size()), 128'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/exec_stage.md
EXEC_STAGE -- requirements
Module: exec_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: datapath width, legal values 8..64.
REQ-002 SHALL have parameter CONTROL_WIDTH, default 4: ALU op width.
REQ-003 SHALL have parameter REG_ADDR_WIDTH, default 5: register index width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have input ports en_i (1), flush_i (1), valid_d_i (1): D/E register hold, bubble, and valid.
REQ-007 SHALL have decode control inputs, each input and registered into E:
- regwrite_d_i (1), resultsrc_d_i (2), memwrite_d_i (1)
- jump_d_i (1), branch_d_i (1), alusrc_d_i (1)
- alucontrol_d_i (CONTROL_WIDTH), funct3_d_i (3)
REQ-008 SHALL have decode data inputs, each input and registered into E:
- rd1_d_i, rd2_d_i, pc_d_i, pcplus4_d_i, extimm_d_i (each DATA_WIDTH)
- rs1_d_i, rs2_d_i, rd_d_i (each REG_ADDR_WIDTH)
REQ-009 SHALL have inputs fwd_a_i (2), fwd_b_i (2) and result_w_i (DATA_WIDTH): forwarding selects and writeback value.
REQ-010 SHALL have outputs to the hazard unit: rs1_e_o, rs2_e_o, rd_e_o (REG_ADDR_WIDTH), resultsrc_e_o (2), busy_o (1).
REQ-011 SHALL have outputs to fetch: pc_src_o (1), pc_target_o (DATA_WIDTH).
REQ-012 SHALL have M-stage outputs, all registered:
- valid_m_o, regwrite_m_o, memwrite_m_o (1), resultsrc_m_o (2), funct3_m_o (3)
- alu_result_m_o, write_data_m_o, pcplus4_m_o (DATA_WIDTH), rd_m_o (REG_ADDR_WIDTH)

Function
REQ-013 D/E register SHALL load on the clock edge when en_i=1; SHALL hold when en_i=0; flush_i=1 SHALL clear valid, regwrite, memwrite, jump and branch, overriding en_i.
REQ-014 Operand A SHALL be selected by fwd_a_i: 00 = rd1_e, 01 = result_w_i, 10 = alu_result_m_o, 11 = rd1_e. Operand B pre-mux (write data) SHALL use the same encoding with fwd_b_i and rd2_e.
REQ-015 SrcB SHALL be extimm_e when alusrc_e=1, otherwise the forwarded write data.
REQ-016 ALU ops SHALL be ADD, SUB, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA, PASSB and MUL:
- all arithmetic is modulo 2^DATA_WIDTH
- shift amount = SrcB[$clog2(DATA_WIDTH)-1:0]
- any unlisted code SHALL produce result 0.
REQ-017 pc_target_o SHALL equal pc_e + extimm_e (wrapping).
REQ-018 pc_src_o SHALL equal valid_e AND (jump_e OR (branch_e AND cond)):
- cond by funct3: BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111
- other funct3 values SHALL give cond = 0.
REQ-019 Non-MUL ops SHALL have 1-cycle latency: the E result is captured into the M register at the next edge.
REQ-020 E/M register SHALL capture every cycle that busy_o=0; when busy_o=1 it SHALL capture a bubble (valid_m_o=0, regwrite_m_o=0, memwrite_m_o=0).

Reset
REQ-021 Asserting rst SHALL asynchronously clear all D/E and E/M fields and the MUL FSM state to zero/IDLE, so every registered output reads 0 and busy_o=0 while rst is low.
REQ-022 Reset asserted mid-multiply SHALL abandon the operation; the first post-reset cycle SHALL be IDLE.

Configuration
REQ-023 Macro EXEC_STAGE_MUL_EN SHALL control the iterative multiplier. When the macro is defined:
- MUL uses an FSM IDLE -> BUSY (DATA_WIDTH shift-add cycles) -> DONE -> IDLE
- busy_o = valid_e AND op==MUL AND state!=DONE
- the DONE cycle presents the low DATA_WIDTH product bits
- flush_i in BUSY returns the FSM to IDLE.
REQ-024 When EXEC_STAGE_MUL_EN is not defined, MUL SHALL produce result 0, busy_o SHALL be constant 0, and no FSM is instantiated.

Structure
REQ-025 A shared package exec_pkg SHALL hold the ALU op enum, the funct3 branch constants, the forwarding-select constants and the MUL FSM state enum.
REQ-026 The multiplier SHALL be a sub-module iter_mul carrying start, busy and done signals.

Verification
REQ-027 Bench SHALL cover ADD with rd1=5, imm=7, alusrc=1 -> alu_result_m_o=12 one edge after E.
REQ-028 Bench SHALL cover forwarding: fwd_a=10 with alu_result_m_o=0x10, rd1=0, rd2=3, SUB -> 0x0D; fwd_a=01 with result_w_i=9 -> 6.
REQ-029 Bench SHALL cover BLT with SrcA=0xFFFFFFFF, SrcB=1 -> pc_src_o=1; BLTU with the same operands -> pc_src_o=0; pc_e=0x100, imm=-8 -> pc_target_o=0xF8.
REQ-030 Bench SHALL cover flush_i=1 and en_i=0 together on a valid jump -> following cycle pc_src_o=0 and valid_m_o=0.
REQ-031 With MUL_EN defined, bench SHALL cover MUL 7*6 -> busy_o high for 32 cycles, alu_result_m_o=42 with valid_m_o=1 after the DONE edge, and bubbles at M meanwhile.
REQ-032 Bench SHALL cover rst pulsed low at MUL cycle 10 -> busy_o=0 and all M outputs 0 immediately, without waiting for a clock edge.
